// File: rtl/tff_pkg.sv
// Shared definitions for the T-flip-flop modulo counter: direction encoding and toggle-vector helper.
// Pure package; no timing or flow control of its own.
package tff_pkg;
  localparam logic DIR_UP = 1'b1;
  localparam logic DIR_DN = 1'b0;

  // Widest counter the toggle helper supports; callers zero-extend and truncate.
  localparam int TFF_MAX_W = 64;

  function automatic logic [TFF_MAX_W-1:0] tff_toggle_vec(input logic [TFF_MAX_W-1:0] q,
                                                          input logic [TFF_MAX_W-1:0] nq);
    return q ^ nq;
  endfunction
endpackage

// File: rtl/tff_mod_counter_if.sv
// Control and status bundle of the modulo counter; slave = counter, master = controller.
// Level signals sampled every clk edge, no handshake or backpressure.
interface tff_mod_counter_if #(
  parameter int WIDTH = 8
) ();
  logic             clr;
  logic             load;
  logic [WIDTH-1:0] load_val;
  logic             en;
  logic             up;
  logic [WIDTH-1:0] max_val;
  logic [WIDTH-1:0] q;
  logic             tc;
  logic             ovf;

  modport master (
    output clr, load, load_val, en, up, max_val,
    input  q, tc, ovf
  );

  modport slave (
    input  clr, load, load_val, en, up, max_val,
    output q, tc, ovf
  );
endinterface

// File: rtl/tff_cell.sv
// One counter bit: T flip-flop, toggles on clk when t is high, async active-high reset to INIT.
// One-edge latency; no backpressure.
module tff_cell #(
  parameter logic INIT = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic t,
  output logic q
);
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q <= INIT;
    end else if (t) begin
      q <= ~q;
    end
  end
endmodule

// File: rtl/tff_mod_counter.sv
// Modulo up/down counter on a bank of T cells with clear/load, wrap-or-saturate, tc pulse and sticky ovf.
// Actions appear on q one clk edge after sampling; no backpressure, inputs are sampled every edge.
module tff_mod_counter
  import tff_pkg::*;
#(
  parameter int             WIDTH     = 8,
  parameter int             SATURATE  = 0,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input logic              clk,
  input logic              rst,
  tff_mod_counter_if.slave bus
);
  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] nq;
  logic [WIDTH-1:0] t;
  logic             bnd;
  logic             tc_r;
  logic             ovf_r;

  // Next state; priority clr > load > en > hold, and only the enabled count can raise a boundary.
  always_comb begin
    nq  = q;
    bnd = 1'b0;
    if (bus.clr) begin
      nq = '0;
    end else if (bus.load) begin
      nq = (bus.load_val > bus.max_val) ? bus.max_val : bus.load_val;
    end else if (bus.en) begin
      unique case (bus.up)
        DIR_UP: begin
          if (q < bus.max_val) begin
            nq = q + WIDTH'(1);
          end else begin
            bnd = 1'b1;
            nq  = (SATURATE != 0) ? bus.max_val : '0;
          end
        end
        DIR_DN: begin
          if (q > bus.max_val) begin
            nq = bus.max_val;
          end else if (q != '0) begin
            nq = q - WIDTH'(1);
          end else begin
            bnd = 1'b1;
            nq  = (SATURATE != 0) ? '0 : bus.max_val;
          end
        end
        default: nq = q;
      endcase
    end
  end

  assign t = WIDTH'(tff_toggle_vec(TFF_MAX_W'(q), TFF_MAX_W'(nq)));

  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    tff_cell #(.INIT(RESET_VAL[i])) u_cell (
      .clk (clk),
      .rst (rst),
      .t   (t[i]),
      .q   (q[i])
    );
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tc_r  <= 1'b0;
      ovf_r <= 1'b0;
    end else if (bus.clr) begin
      tc_r  <= 1'b0;
      ovf_r <= 1'b0;
    end else begin
      tc_r <= bnd;
      if (bnd) begin
        ovf_r <= 1'b1;
      end
    end
  end

  assign bus.q   = q;
  assign bus.tc  = tc_r;
  assign bus.ovf = ovf_r;
endmodule

// File: tb/tb_tff_mod_counter.sv
// Directed and randomized check of tff_mod_counter against an integer reference model.
module tb_tff_mod_counter;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int   ncmp = 0;
  int   nerr = 0;

  always #5 clk = ~clk;

  tff_mod_counter_if #(.WIDTH(4)) ia ();
  tff_mod_counter_if #(.WIDTH(4)) ib ();
  tff_mod_counter_if #(.WIDTH(1)) ic ();
  tff_mod_counter_if #(.WIDTH(8)) id ();
  tff_mod_counter_if #(.WIDTH(8)) ie ();

  tff_mod_counter #(.WIDTH(4), .SATURATE(0), .RESET_VAL(4'd3)) u_a (.clk(clk), .rst(rst), .bus(ia));
  tff_mod_counter #(.WIDTH(4), .SATURATE(1), .RESET_VAL(4'd0)) u_b (.clk(clk), .rst(rst), .bus(ib));
  tff_mod_counter #(.WIDTH(1), .SATURATE(0), .RESET_VAL(1'b0)) u_c (.clk(clk), .rst(rst), .bus(ic));
  tff_mod_counter #(.WIDTH(8), .SATURATE(0), .RESET_VAL(8'd0)) u_d (.clk(clk), .rst(rst), .bus(id));
  tff_mod_counter #(.WIDTH(8), .SATURATE(1), .RESET_VAL(8'd0)) u_e (.clk(clk), .rst(rst), .bus(ie));

  typedef struct packed {
    int unsigned q;
    bit          tc;
    bit          ovf;
  } ms_t;

  // Behavioural model: integer arithmetic straight from the counting rules.
  function automatic ms_t ref_next(ms_t s, bit sat, bit clr, bit load, bit en, bit up,
                                   int unsigned lv, int unsigned mx);
    ms_t n   = s;
    bit  hit = 1'b0;
    n.tc = 1'b0;
    if (clr) begin
      n.q   = 0;
      n.ovf = 1'b0;
    end else if (load) begin
      n.q = (lv < mx) ? lv : mx;
    end else if (en) begin
      if (up) begin
        if (s.q < mx) n.q = s.q + 1;
        else begin hit = 1'b1; n.q = sat ? mx : 0; end
      end else begin
        if (s.q > mx)      n.q = mx;
        else if (s.q > 0)  n.q = s.q - 1;
        else begin hit = 1'b1; n.q = sat ? 0 : mx; end
      end
    end
    if (hit) begin
      n.tc  = 1'b1;
      n.ovf = 1'b1;
    end
    return n;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_a(input bit clr, input bit load, input int lv, input bit en, input bit up, input int mx);
    ia.clr = clr; ia.load = load; ia.load_val = 4'(lv);
    ia.en = en; ia.up = up; ia.max_val = 4'(mx);
  endtask

  task automatic set_b(input bit load, input int lv, input bit en, input bit up, input int mx);
    ib.clr = 1'b0; ib.load = load; ib.load_val = 4'(lv);
    ib.en = en; ib.up = up; ib.max_val = 4'(mx);
  endtask

  task automatic chk_a(input string tag, input int q, input bit tc, input bit ovf);
    chk({tag, ".q"}, 32'(ia.q), 32'(q));
    chk({tag, ".tc"}, 32'(ia.tc), 32'(tc));
    chk({tag, ".ovf"}, 32'(ia.ovf), 32'(ovf));
  endtask

  // Random-phase state for instances c (W1), d (W8 wrap), e (W8 saturate).
  int unsigned mask[3] = '{1, 255, 255};
  bit          satv[3] = '{1'b0, 1'b0, 1'b1};
  int unsigned mxv[3];
  ms_t         st[3];
  ms_t         nx[3];

  task automatic rand_drive();
    bit          rc, rl, re, ru;
    int unsigned lv;
    for (int k = 0; k < 3; k++) begin
      rc = ($urandom_range(31) == 0);
      rl = ($urandom_range(15) == 0);
      re = ($urandom_range(3) != 0);
      ru = 1'($urandom_range(1));
      lv = $urandom & mask[k];
      if ($urandom_range(7) == 0) mxv[k] = $urandom & mask[k];
      nx[k] = ref_next(st[k], satv[k], rc, rl, re, ru, lv, mxv[k]);
      case (k)
        0: begin ic.clr = rc; ic.load = rl; ic.en = re; ic.up = ru;
                 ic.load_val = 1'(lv); ic.max_val = 1'(mxv[k]); end
        1: begin id.clr = rc; id.load = rl; id.en = re; id.up = ru;
                 id.load_val = 8'(lv); id.max_val = 8'(mxv[k]); end
        default: begin ie.clr = rc; ie.load = rl; ie.en = re; ie.up = ru;
                 ie.load_val = 8'(lv); ie.max_val = 8'(mxv[k]); end
      endcase
    end
  endtask

  initial begin
    set_a(0, 0, 0, 0, 1, 15);
    set_b(0, 0, 0, 1, 15);
    ib.clr = 1'b0;
    ic.clr = 0; ic.load = 0; ic.load_val = '0; ic.en = 0; ic.up = 0; ic.max_val = '1;
    id.clr = 0; id.load = 0; id.load_val = '0; id.en = 0; id.up = 0; id.max_val = '1;
    ie.clr = 0; ie.load = 0; ie.load_val = '0; ie.en = 0; ie.up = 0; ie.max_val = '1;

    // Reset asserted between edges takes effect at once.
    #12 rst = 1'b1;
    #1  chk_a("reset", 3, 0, 0);
    #4  rst = 1'b0;
    set_a(0, 0, 0, 1, 1, 15);
    tick(); chk_a("count1", 4, 0, 0);
    tick(); chk_a("count2", 5, 0, 0);
    tick(); chk_a("count3", 6, 0, 0);

    // Wrap up at max_val=9.
    set_a(0, 1, 8, 0, 1, 9);
    tick(); chk_a("load8", 8, 0, 0);
    set_a(0, 0, 0, 1, 1, 9);
    tick(); chk_a("wrap_up9", 9, 0, 0);
    tick(); chk_a("wrap_up0", 0, 1, 1);
    tick(); chk_a("wrap_up1", 1, 0, 1);

    // Wrap down from 0.
    set_a(0, 1, 0, 0, 0, 9);
    tick(); chk_a("load0", 0, 0, 1);
    set_a(0, 0, 0, 1, 0, 9);
    tick(); chk_a("wrap_dn", 9, 1, 1);

    // Saturating instance holds at max_val with tc held high.
    set_b(1, 9, 0, 1, 9);
    tick();
    chk("sat_load.q", 32'(ib.q), 9);
    set_b(0, 0, 1, 1, 9);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("sat_hold.q", 32'(ib.q), 9);
      chk("sat_hold.tc", 32'(ib.tc), 1);
      chk("sat_hold.ovf", 32'(ib.ovf), 1);
    end
    // max_val=0: every enabled edge is a boundary.
    set_b(1, 5, 0, 1, 0);
    tick(); chk("max0_load.q", 32'(ib.q), 0); chk("max0_load.tc", 32'(ib.tc), 0);
    set_b(0, 0, 1, 0, 0);
    tick(); chk("max0_dn.q", 32'(ib.q), 0); chk("max0_dn.tc", 32'(ib.tc), 1);
    set_b(0, 0, 0, 1, 0);
    tick(); chk("max0_idle.tc", 32'(ib.tc), 0);

    // Priority clr > load > en, then clamped load.
    set_a(1, 1, 5, 1, 1, 9);
    tick(); chk_a("clr_pri", 0, 0, 0);
    set_a(0, 1, 12, 0, 1, 9);
    tick(); chk_a("load_clamp", 9, 0, 0);

    // Run-time modulus changes.
    set_a(0, 1, 7, 0, 1, 9);
    tick(); chk_a("load7", 7, 0, 0);
    set_a(0, 0, 0, 1, 1, 5);
    tick(); chk_a("above_max_up", 0, 1, 1);
    set_a(0, 1, 7, 0, 1, 15);
    tick(); chk_a("reload7", 7, 0, 1);
    set_a(0, 0, 0, 1, 0, 15);
    tick(); chk_a("down_no_event", 6, 0, 1);

    // Hold.
    set_a(0, 0, 0, 0, 1, 15);
    for (int i = 0; i < 4; i++) begin
      tick(); chk_a("hold", 6, 0, 1);
    end

    // Reset mid-count clears a live tc pulse.
    set_a(0, 1, 6, 0, 1, 6);
    tick(); chk_a("load6", 6, 0, 1);
    set_a(0, 0, 0, 1, 1, 6);
    tick(); chk_a("wrap6", 0, 1, 1);
    #2 rst = 1'b1;
    #1 chk_a("mid_rst", 3, 0, 0);
    #1 rst = 1'b0;
    set_a(0, 0, 0, 0, 1, 15);

    // Randomized run against the model.
    for (int k = 0; k < 3; k++) begin
      st[k]  = '{q: 0, tc: 1'b0, ovf: 1'b0};
      mxv[k] = mask[k];
    end
    rand_drive();
    repeat (1000) begin
      tick();
      st = nx;
      chk("w1.q", 32'(ic.q), st[0].q);   chk("w1.tc", 32'(ic.tc), 32'(st[0].tc));
      chk("w1.ovf", 32'(ic.ovf), 32'(st[0].ovf));
      chk("w8.q", 32'(id.q), st[1].q);   chk("w8.tc", 32'(id.tc), 32'(st[1].tc));
      chk("w8.ovf", 32'(id.ovf), 32'(st[1].ovf));
      chk("w8s.q", 32'(ie.q), st[2].q);  chk("w8s.tc", 32'(ie.tc), 32'(st[2].tc));
      chk("w8s.ovf", 32'(ie.ovf), 32'(st[2].ovf));
      rand_drive();
      #1;
      // Toggle vector must flip exactly the bits that differ between now and next.
      chk("w8.toggle", 32'(u_d.t), (st[1].q ^ nx[1].q) & 32'hFF);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end
endmodule
